// File: rtl/cache_ctrl.sv
// Direct-mapped write-through word cache: read hit 1 cycle, misses/writes go to backing memory.
// Stalls caller through o_busy while INIT, RD_MISS or WR_MEM is in progress; memory side waits on mem_ack.
module cache_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINES      = 256
) (
   input  logic                  clk,
   input  logic                  rst_x,
   input  logic [31:0]           d_pc,
   output logic                  w_init_done,
   input  logic                  i_rd_en,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [31:0]           i_data,
   input  logic [3:0]            i_mask,
   output logic [31:0]           o_data,
   output logic                  o_busy,
   output logic [6:0]            state,
   output logic                  c_oe,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_wmask,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_ack
);

   localparam int IDX  = $clog2(LINES);
   localparam int TAGW = ADDR_WIDTH - IDX - 2;

   typedef enum logic [1:0] {
      S_INIT    = 2'd0,
      S_IDLE    = 2'd1,
      S_RD_MISS = 2'd2,
      S_WR_MEM  = 2'd3
   } st_t;

   st_t st, st_nxt;

   logic [IDX:0]    init_cnt;
   logic [LINES-1:0] line_vld;
   logic [TAGW-1:0] line_tag [LINES];
   logic [31:0]     line_dat [LINES];

   logic [IDX-1:0]  req_idx, fill_idx;
   logic [TAGW-1:0] req_tag, fill_tag;
   logic            hit, rd_go, wr_go, init_last;
   logic            busy_nxt, req_nxt, c_oe_nxt;
   logic            unused_ok;

   assign req_idx   = i_addr[IDX+1:2];
   assign req_tag   = i_addr[ADDR_WIDTH-1:IDX+2];
   assign fill_idx  = mem_addr[IDX+1:2];
   assign fill_tag  = mem_addr[ADDR_WIDTH-1:IDX+2];
   assign hit       = line_vld[req_idx] && (line_tag[req_idx] == req_tag);
   assign rd_go     = (st == S_IDLE) && i_rd_en;
   assign wr_go     = (st == S_IDLE) && i_wr_en && !i_rd_en;
   // Counter runs one past the last line so IDLE is reached LINES+1 cycles after reset release
   assign init_last = (init_cnt == (IDX+1)'(LINES));
   assign state     = {5'b0, st};
   assign unused_ok = &{1'b0, d_pc, i_addr[1:0]};

   always_ff @(posedge clk) begin
      if (rst_x) st <= S_INIT;
      else       st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      case (st)
         S_INIT:    if (init_last) st_nxt = S_IDLE;
         S_IDLE: begin
            if (rd_go && !hit) st_nxt = S_RD_MISS;
            else if (wr_go)    st_nxt = S_WR_MEM;
         end
         S_RD_MISS: if (mem_ack) st_nxt = S_IDLE;
         S_WR_MEM:  if (mem_ack) st_nxt = S_IDLE;
         default:   st_nxt = S_INIT;
      endcase
   end

   always_comb begin
      busy_nxt = (st_nxt != S_IDLE);
      req_nxt  = (st_nxt == S_RD_MISS) || (st_nxt == S_WR_MEM);
      c_oe_nxt = rd_go && hit;
   end

   always_ff @(posedge clk) begin
      if (rst_x) begin
         o_busy      <= 1'b1;
         w_init_done <= 1'b0;
         o_data      <= '0;
         c_oe        <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_wmask   <= '0;
         init_cnt    <= '0;
      end else begin
         o_busy  <= busy_nxt;
         c_oe    <= c_oe_nxt;
         mem_req <= req_nxt;
         if (st == S_INIT && !init_last) init_cnt <= init_cnt + 1'b1;
         if (st == S_INIT && init_last)  w_init_done <= 1'b1;
         if (rd_go) begin
            mem_addr <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_we   <= 1'b0;
            if (hit) o_data <= line_dat[req_idx];
         end else if (wr_go) begin
            mem_addr  <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_we    <= 1'b1;
            mem_wdata <= i_data;
            mem_wmask <= i_mask;
         end
         if (st == S_RD_MISS && mem_ack) o_data <= mem_rdata;
      end
   end

   // Line storage carries no reset; INIT walks the valid bits instead
   always_ff @(posedge clk) begin
      if (!rst_x) begin
         if (st == S_INIT && !init_last)
            line_vld[init_cnt[IDX-1:0]] <= 1'b0;
         if (st == S_RD_MISS && mem_ack) begin
            line_vld[fill_idx] <= 1'b1;
            line_tag[fill_idx] <= fill_tag;
            line_dat[fill_idx] <= mem_rdata;
         end
         if (wr_go && hit) begin
            for (int b = 0; b < 4; b++)
               if (i_mask[b]) line_dat[req_idx][8*b +: 8] <= i_data[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// Random + directed bench for cache_ctrl: a memory-level reference model predicts hit/miss and data,
// expectations are queued at issue time and popped by an independent output monitor.
module tb_cache_ctrl;
   localparam int AW    = 32;
   localparam int LINES = 256;

   logic          clk = 1'b0;
   logic          rst_x;
   logic [31:0]   d_pc;
   logic          w_init_done;
   logic          i_rd_en, i_wr_en;
   logic [AW-1:0] i_addr;
   logic [31:0]   i_data;
   logic [3:0]    i_mask;
   logic [31:0]   o_data;
   logic          o_busy;
   logic [6:0]    state;
   logic          c_oe;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_wmask;
   logic [31:0]   mem_rdata;
   logic          mem_ack;

   always #5 clk = ~clk;

   cache_ctrl #(.ADDR_WIDTH(AW), .LINES(LINES)) dut (
      .clk(clk), .rst_x(rst_x), .d_pc(d_pc), .w_init_done(w_init_done),
      .i_rd_en(i_rd_en), .i_wr_en(i_wr_en), .i_addr(i_addr), .i_data(i_data),
      .i_mask(i_mask), .o_data(o_data), .o_busy(o_busy), .state(state), .c_oe(c_oe),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   typedef struct {bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wmask;} mreq_t;
   typedef struct {bit hit; logic [31:0] data;} rd_t;

   mreq_t       exp_mem[$];
   rd_t         exp_rd[$];
   logic [31:0] ref_mem  [logic [31:0]];
   logic [31:0] phys_mem [logic [31:0]];
   bit          mdl_vld [LINES];
   logic [31:0] mdl_wa  [LINES];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: actual=event required=none", name);
   endtask

   function automatic logic [31:0] dflt(input logic [31:0] wa);
      return (wa * 32'h9E3779B1) ^ 32'hC0FFEE11;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] wa);
      if (ref_mem.exists(wa)) return ref_mem[wa];
      return dflt(wa);
   endfunction

   function automatic logic [31:0] phys_rd(input logic [31:0] wa);
      if (phys_mem.exists(wa)) return phys_mem[wa];
      return dflt(wa);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] m);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Backing memory: acks after ack_dly cycles (random when negative)
   int          ack_dly  = -1;
   bit          auto_ack = 1'b1;
   bit          late_ack = 1'b0;
   int          rsp_d;
   logic [31:0] rsp_wa;
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (late_ack) begin
            mem_rdata = 32'h12345678;
            mem_ack   = 1'b1;
            @(negedge clk);
            mem_ack   = 1'b0;
            late_ack  = 1'b0;
         end else if (mem_req && auto_ack && !rst_x) begin
            rsp_d = (ack_dly >= 0) ? ack_dly : int'($urandom_range(0, 3));
            repeat (rsp_d) @(negedge clk);
            rsp_wa = mem_addr >> 2;
            if (mem_we) phys_mem[rsp_wa] = merge(phys_rd(rsp_wa), mem_wdata, mem_wmask);
            else        mem_rdata = phys_rd(rsp_wa);
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
         end
      end
   end

   // Monitor: read completions, o_data hold, memory requests
   bit          mon_prev_req;
   logic [6:0]  mon_prev_st;
   logic [31:0] mon_last_od;
   bit          mon_rd_done;
   rd_t         mr;
   mreq_t       mm;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst_x) begin
            mon_prev_req = 1'b0;
            mon_prev_st  = '0;
            mon_last_od  = '0;
         end else begin
            mon_rd_done = 1'b0;
            if (c_oe) begin
               mon_rd_done = 1'b1;
               if (exp_rd.size() == 0) fail_now("rd_unexpected_hit");
               else begin
                  mr = exp_rd.pop_front();
                  check("rd_is_hit", 32'd1, {31'b0, mr.hit});
                  check("rd_hit_data", o_data, mr.data);
                  mon_last_od = mr.data;
               end
            end else if (mon_prev_st == 7'd2 && state == 7'd1) begin
               mon_rd_done = 1'b1;
               if (exp_rd.size() == 0) fail_now("rd_unexpected_miss");
               else begin
                  mr = exp_rd.pop_front();
                  check("rd_is_miss", 32'd0, {31'b0, mr.hit});
                  check("rd_miss_data", o_data, mr.data);
                  mon_last_od = mr.data;
               end
            end
            if (!mon_rd_done) check("o_data_hold", o_data, mon_last_od);
            if (mem_req && !mon_prev_req) begin
               if (exp_mem.size() == 0) fail_now("mem_unexpected_req");
               else begin
                  mm = exp_mem.pop_front();
                  check("mem_we", {31'b0, mem_we}, {31'b0, mm.we});
                  check("mem_addr", mem_addr, mm.addr);
                  if (mm.we) begin
                     check("mem_wdata", mem_wdata, mm.wdata);
                     check("mem_wmask", {28'b0, mem_wmask}, {28'b0, mm.wmask});
                  end
               end
            end
            mon_prev_req = mem_req;
            mon_prev_st  = state;
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (o_busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (o_busy) fail_now("idle_timeout");
   endtask

   task automatic model_read(input logic [31:0] a, output bit hit);
      logic [31:0] wa;
      int idx;
      wa  = a >> 2;
      idx = int'(wa % LINES);
      hit = mdl_vld[idx] && (mdl_wa[idx] == wa);
      exp_rd.push_back('{hit: hit, data: ref_rd(wa)});
      if (!hit) begin
         exp_mem.push_back('{we: 1'b0, addr: wa << 2, wdata: 32'h0, wmask: 4'h0});
         mdl_vld[idx] = 1'b1;
         mdl_wa[idx]  = wa;
      end
   endtask

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      logic [31:0] wa;
      wa = a >> 2;
      exp_mem.push_back('{we: 1'b1, addr: wa << 2, wdata: d, wmask: m});
      ref_mem[wa] = merge(ref_rd(wa), d, m);
   endtask

   task automatic do_read(input logic [31:0] a);
      bit h;
      wait_idle();
      model_read(a, h);
      i_addr  = a;
      i_rd_en = 1'b1;
      @(negedge clk);
      i_rd_en = 1'b0;
      if (!h) wait_idle();
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input bit both);
      bit h;
      int n = 0;
      wait_idle();
      if (both) model_read(a, h);
      model_write(a, d, m);
      i_addr  = a;
      i_data  = d;
      i_mask  = m;
      i_wr_en = 1'b1;
      i_rd_en = both;
      @(negedge clk);
      i_rd_en = 1'b0;
      while (state != 7'd3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (state != 7'd3) fail_now("wr_accept_timeout");
      i_wr_en = 1'b0;
   endtask

   task automatic wait_init(input int start, input string name);
      int n = start;
      while (o_busy && n < 2000) begin
         @(negedge clk);
         n++;
         if (n == LINES) check({name, "_busy_before"}, {31'b0, o_busy}, 32'd1);
      end
      check({name, "_cycles"}, n, LINES + 1);
      check({name, "_done"}, {31'b0, w_init_done}, 32'd1);
      check({name, "_state"}, state, 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      int r;
      rst_x = 1'b1; d_pc = '0; i_rd_en = 1'b0; i_wr_en = 1'b0;
      i_addr = '0; i_data = '0; i_mask = '0;
      repeat (3) @(negedge clk);
      check("rst_state", state, 32'd0);
      check("rst_busy", {31'b0, o_busy}, 32'd1);
      check("rst_init_done", {31'b0, w_init_done}, 32'd0);
      check("rst_odata", o_data, 32'd0);
      check("rst_coe", {31'b0, c_oe}, 32'd0);
      check("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check("rst_mem_we", {31'b0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_mem_wmask", {28'b0, mem_wmask}, 32'd0);
      rst_x = 1'b0;
      wait_init(0, "init");

      ref_mem[32'h40]  = 32'hDEADBEEF;
      phys_mem[32'h40] = 32'hDEADBEEF;
      ack_dly = 3;
      do_read(32'h100);
      check("dir_miss_data", o_data, 32'hDEADBEEF);
      do_read(32'h100);
      @(negedge clk);
      do_write(32'h100, 32'h0000_00AA, 4'b0001, 1'b0);
      do_read(32'h100);
      @(negedge clk);
      check("dir_write_hit_data", o_data, 32'hDEADBEAA);
      do_write(32'h200, 32'h5555_6666, 4'hF, 1'b0);
      do_read(32'h200);
      do_read(32'h100);
      do_read(32'h500);
      do_read(32'h100);
      ack_dly = 0;
      do_write(32'h500, 32'hA1B2C3D4, 4'b1010, 1'b1);
      do_write(32'h500, 32'h0F0F0F0F, 4'b0101, 1'b1);

      ack_dly = -1;
      repeat (400) begin
         a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
         d_pc = $urandom;
         r = int'($urandom_range(0, 9));
         if (r < 5)      do_read(a);
         else if (r < 9) do_write(a, $urandom, 4'($urandom), 1'b0);
         else            do_write(a, $urandom, 4'($urandom), 1'b1);
      end

      wait_idle();
      auto_ack = 1'b0;
      exp_mem.push_back('{we: 1'b0, addr: 32'h3000, wdata: 32'h0, wmask: 4'h0});
      i_addr  = 32'h3000;
      i_rd_en = 1'b1;
      @(negedge clk);
      i_rd_en = 1'b0;
      check("rm_state", state, 32'd2);
      check("rm_req", {31'b0, mem_req}, 32'd1);
      @(negedge clk);
      rst_x = 1'b1;
      @(negedge clk);
      check("rm_rst_req_drop", {31'b0, mem_req}, 32'd0);
      check("rm_rst_state", state, 32'd0);
      rst_x = 1'b0;
      for (int k = 0; k < LINES; k++) mdl_vld[k] = 1'b0;
      late_ack = 1'b1;
      wait_init(0, "reinit");
      check("late_ack_odata", o_data, 32'd0);
      auto_ack = 1'b1;
      do_read(32'h3000);
      do_read(32'h3000);

      wait_idle();
      repeat (5) @(negedge clk);
      check("exp_rd_drained", exp_rd.size(), 32'd0);
      check("exp_mem_drained", exp_mem.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
